// File: rtl/pld_shift_rx.sv
// Serial-in word receiver with start strobe, sen-qualified sampling and valid/ready output.
// Define PLD_SHIFT_RX_PARITY_EN to append one even-parity bit per word (PAR state, perr output).
module pld_shift_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sen,
    input  logic             sin,
    input  logic             dready,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic             busy,
    output logic             ovr,
    output logic             perr
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PLD_SHIFT_RX_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift, word;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovr_q, ovr_d;
    logic             done;
`ifdef PLD_SHIFT_RX_PARITY_EN
    logic             perr_q, perr_d, perr_new;
`endif

    assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        word    = sr_shift;
        done    = 1'b0;
`ifdef PLD_SHIFT_RX_PARITY_EN
        perr_new = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sen) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
`ifdef PLD_SHIFT_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        done    = 1'b1;
`endif
                    end
                end
            end
`ifdef PLD_SHIFT_RX_PARITY_EN
            PAR: begin
                // data word is already complete in sr_q; sin here is the parity bit
                if (sen) begin
                    state_d  = IDLE;
                    done     = 1'b1;
                    word     = sr_q;
                    perr_new = (^sr_q) ^ sin;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovr_d    = ovr_q;
`ifdef PLD_SHIFT_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        if (done) begin
            if (!dvalid_q || dready) begin
                dout_d   = word;
                dvalid_d = 1'b1;
`ifdef PLD_SHIFT_RX_PARITY_EN
                perr_d   = perr_new;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (dvalid_q && dready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef PLD_SHIFT_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
`ifdef PLD_SHIFT_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = (state_q != IDLE);
    assign ovr    = ovr_q;
`ifdef PLD_SHIFT_RX_PARITY_EN
    assign perr   = perr_q;
`else
    assign perr   = 1'b0;
`endif

endmodule

// File: tb/tb_pld_shift_rx.sv
// Bench for pld_shift_rx: MSB-first and LSB-first instances share stimulus; a frame-level
// reference model (bit queue per frame) predicts all outputs every cycle.
module tb_pld_shift_rx;

    localparam int W = 8;
`ifdef PLD_SHIFT_RX_PARITY_EN
    localparam bit PEN  = 1'b1;
    localparam int FLEN = W + 1;
`else
    localparam bit PEN  = 1'b0;
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst, start, sen, sin, dready;
    logic [W-1:0] dout_m, dout_l;
    logic dvalid_m, busy_m, ovr_m, perr_m;
    logic dvalid_l, busy_l, ovr_l, perr_l;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    bit           m_busy;
    bit           mq[$];
    logic [W-1:0] m_dm, m_dl;
    bit           m_dv, m_ovr, m_perr;

    always #5 clk = ~clk;

    pld_shift_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .sen(sen), .sin(sin), .dready(dready),
        .dout(dout_m), .dvalid(dvalid_m), .busy(busy_m), .ovr(ovr_m), .perr(perr_m)
    );

    pld_shift_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .sen(sen), .sin(sin), .dready(dready),
        .dout(dout_l), .dvalid(dvalid_l), .busy(busy_l), .ovr(ovr_l), .perr(perr_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit           complete;
        logic [W-1:0] wm, wl;
        bit           p;
        complete = 1'b0;
        if (!rst) begin
            m_busy = 1'b0; mq.delete();
            m_dm = '0; m_dl = '0; m_dv = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            return;
        end
        if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                mq.delete();
            end
        end else if (sen) begin
            mq.push_back(sin);
            if (mq.size() == FLEN) begin
                complete = 1'b1;
                m_busy   = 1'b0;
            end
        end
        if (complete) begin
            wm = '0; wl = '0; p = 1'b0;
            for (int i = 0; i < W; i++) begin
                wm[W-1-i] = mq[i];
                wl[i]     = mq[i];
                p         = p ^ mq[i];
            end
            if (PEN) p = p ^ mq[W];
            else     p = 1'b0;
            if (!m_dv || dready) begin
                m_dm = wm; m_dl = wl; m_dv = 1'b1; m_perr = p;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_dv && dready) begin
            m_dv = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit e, input bit d, input bit rd);
        rst = r; start = s; sen = e; sin = d; dready = rd;
        @(posedge clk);
        model_update();
        #1;
        chk("dout_msb",   32'(dout_m),   32'(m_dm));
        chk("dout_lsb",   32'(dout_l),   32'(m_dl));
        chk("dvalid_msb", 32'(dvalid_m), 32'(m_dv));
        chk("dvalid_lsb", 32'(dvalid_l), 32'(m_dv));
        chk("busy_msb",   32'(busy_m),   32'(m_busy));
        chk("busy_lsb",   32'(busy_l),   32'(m_busy));
        chk("ovr_msb",    32'(ovr_m),    32'(m_ovr));
        chk("ovr_lsb",    32'(ovr_l),    32'(m_ovr));
        chk("perr_msb",   32'(perr_m),   32'(m_perr));
        chk("perr_lsb",   32'(perr_l),   32'(m_perr));
    endtask

    // Sends w first-bit = w[W-1]; gap inserts a sen=0 cycle before every bit.
    task automatic send_word(input logic [W-1:0] w, input bit gap, input bit badpar, input bit rd);
        step(1, 1, 0, 0, rd);
        for (int i = 0; i < W; i++) begin
            if (gap) step(1, 0, 0, 1'($urandom), rd);
            step(1, 0, 1, w[W-1-i], rd);
        end
        if (PEN) step(1, 0, 1, (^w) ^ badpar, rd);
    endtask

    initial begin
        m_busy = 0; m_dm = '0; m_dl = '0; m_dv = 0; m_ovr = 0; m_perr = 0;
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        chk("reset_dout", 32'(dout_m), 32'h0);
        chk("reset_busy", 32'(busy_m), 32'h0);

        send_word(8'h81, 0, 0, 0);
        chk("f81_dout_msb", 32'(dout_m), 32'h81);
        chk("f81_dvalid", 32'(dvalid_m), 32'h1);
        chk("f81_busy", 32'(busy_m), 32'h0);
        step(1, 0, 0, 0, 1);

        send_word(8'h90, 0, 0, 0);
        chk("f09_dout_lsb", 32'(dout_l), 32'h09);
        step(1, 0, 0, 0, 1);

        send_word(8'h41, 1, 0, 0);
        chk("f41_gap_dout", 32'(dout_m), 32'h41);
        step(1, 0, 0, 0, 1);

        send_word(8'h09, 0, 0, 0);
        send_word(8'h41, 0, 0, 0);
        chk("ovr_dout", 32'(dout_m), 32'h09);
        chk("ovr_flag", 32'(ovr_m), 32'h1);
        step(1, 0, 0, 0, 1);
        chk("ovr_drain_dvalid", 32'(dvalid_m), 32'h0);
        chk("ovr_sticky", 32'(ovr_m), 32'h1);

        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
        step(0, 1, 1, 1, 1);
        chk("midrst_busy", 32'(busy_m), 32'h0);
        chk("midrst_ovr", 32'(ovr_m), 32'h0);
        send_word(8'hA5, 0, 0, 0);
        chk("fA5_dout", 32'(dout_m), 32'hA5);
        step(1, 0, 0, 0, 1);

        if (PEN) begin
            send_word(8'h01, 0, 0, 0);
            chk("par_ok_perr", 32'(perr_m), 32'h0);
            step(1, 0, 0, 0, 1);
            send_word(8'h01, 0, 1, 0);
            chk("par_bad_perr", 32'(perr_m), 32'h1);
        end

        for (int c = 0; c < 4000; c++) begin
            step(($urandom % 150) != 0, ($urandom % 4) == 0, ($urandom % 10) < 7,
                 1'($urandom), ($urandom % 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pld_shift_rx.md
PLD_SHIFT_RX -- requirements
Module: pld_shift_rx

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (legal 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit lands in dout[WIDTH-1], 0 = first bit lands in dout[0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 start  input  1  frame start strobe; begins reception when sampled high in IDLE.
REQ-006 sen  input  1  serial enable; sin is sampled only on edges where sen=1 in SHIFT/PAR.
REQ-007 sin  input  1  serial data bit.
REQ-008 dready  input  1  consumer accepts dout when high while dvalid=1.
REQ-009 dout  output  WIDTH  last completed received word.
REQ-010 dvalid  output  1  dout holds an unconsumed word.
REQ-011 busy  output  1  high in SHIFT or PAR, low in IDLE.
REQ-012 ovr  output  1  sticky overrun flag.
REQ-013 perr  output  1  parity error for current dout (PARITY_EN only; constant 0 otherwise).

Function
REQ-014 FSM states: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
REQ-015 IDLE -> SHIFT on edge with start=1; bit counter cleared to 0; sen/sin ignored on that edge.
REQ-016 SHIFT: each edge with sen=1 shifts sin into internal shift register and increments counter; sen=0 edges hold state.
REQ-017 Shift direction: MSB_FIRST=1 shifts left inserting at bit 0; MSB_FIRST=0 shifts right inserting at bit WIDTH-1.
REQ-018 On the edge sampling bit WIDTH-1 without PARITY_EN: word completes, FSM -> IDLE.
REQ-019 With PARITY_EN, that edge -> PAR; next sen=1 edge samples parity bit, word completes, FSM -> IDLE.
REQ-020 Word completion: if dvalid=0 or dready=1 on that edge, dout <= word, dvalid <= 1 on the same edge (visible the following cycle).
REQ-021 Word completion with dvalid=1 and dready=0: new word discarded, dout/dvalid/perr unchanged, ovr <= 1.
REQ-022 dvalid=1 and dready=1 with no completion: dvalid <= 0; dout holds value.
REQ-023 dready while dvalid=0: no effect.
REQ-024 start while busy=1: ignored; no restart.
REQ-025 start on the same edge a word completes: ignored; a new frame requires start in IDLE.
REQ-026 ovr cleared only by reset.
REQ-027 Counter width ceil(log2(WIDTH))+1 bits; no wrap beyond WIDTH.

Reset
REQ-028 On rst=0 at a rising edge: FSM=IDLE, counter=0, shift register=0, dout=0, dvalid=0, busy=0, ovr=0, perr=0.
REQ-029 Reset mid-frame abandons the partial word; no completion, no ovr.
REQ-030 Reset dominates start, sen, dready on the same edge.

Configuration
REQ-031 Macro PLD_SHIFT_RX_PARITY_EN: when defined, one even-parity bit follows each data word; perr <= (XOR of data bits) XOR parity bit, loaded with dout.
REQ-032 Without the macro: PAR state, parity logic absent; perr tied 0; frame is exactly WIDTH sen-qualified bits.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, start then sin=1,0,0,0,0,0,0,1 with sen=1 every cycle -> dout=8'h81, dvalid=1 the cycle after 8th bit, busy low.
REQ-034 Same frame, MSB_FIRST=0, bits 1,0,0,1,0,0,0,0 -> dout=8'h09.
REQ-035 sen toggling 1,0,1,0 across frame 8'h41 -> dout=8'h41 after 8 sen-qualified edges, counter holds on sen=0 edges.
REQ-036 Two frames 8'h09 then 8'h41, dready=0 throughout -> dout=8'h09, dvalid=1, ovr=1; then dready=1 one cycle -> dvalid=0, ovr stays 1.
REQ-037 rst=0 after 4 bits of a frame -> all outputs 0, IDLE; new frame 8'hA5 afterward received correctly.
REQ-038 PARITY_EN: frame 8'h01 with parity bit 1 -> perr=0; with parity bit 0 -> perr=1; dvalid asserted one sen edge later than without macro.
